// File: rtl/edge_irq_controller.sv
// edge_irq_controller
//   Per-channel edge/level interrupt detection with pending latches, a fixed
//   priority arbiter (channel 0 highest) and a three-state request/service FSM
//   (IDLE -> REQ -> ACTIVE -> IDLE) towards a single CPU.
//
// Build option:
//   IRQ_SYNC_EN  defined   : each irqIn bit passes a 2-flop synchronizer before
//                            detection (irqReq four edges after the sampling edge).
//                undefined : irqIn feeds detection directly (synchronous sources
//                            only, irqReq two edges after the sampling edge).
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   irqIn      raw interrupt sources
//   cfgWe      one-cycle config write strobe
//   cfgAddr    0=enable, 1=mode (1=level), 2=polarity (1=falling/low), 3=pending W1C
//   cfgData    config write data
//   irqAck     CPU accepts the presented request
//   irqDone    CPU end of service
//   irqReq     request to CPU (REQ state)
//   irqId      channel requested or in service
//   irqActive  service in progress (ACTIVE state)
//   pending    raw pending bits
module edge_irq_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irqIn,
    input  logic               cfgWe,
    input  logic [1:0]         cfgAddr,
    input  logic [NUM_IRQ-1:0] cfgData,
    input  logic               irqAck,
    input  logic               irqDone,
    output logic               irqReq,
    output logic [ID_W-1:0]    irqId,
    output logic               irqActive,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] polarity;
    logic [NUM_IRQ-1:0] cond;
    logic [NUM_IRQ-1:0] hist;

    logic [NUM_IRQ-1:0] act_now;
    logic [NUM_IRQ-1:0] act_old;
    logic [NUM_IRQ-1:0] edge_evt;
    logic [NUM_IRQ-1:0] id_mask;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] req_vec;
    logic [NUM_IRQ-1:0] pending_next;
    logic               cur_live;
    logic               accept;

    function automatic logic [ID_W-1:0] lowest_index(input logic [NUM_IRQ-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irqIn;
            sync2 <= sync1;
        end
    end

    assign cond = sync2;
`else
    assign cond = irqIn;
`endif

    // Detection works on "active" values (polarity folded in), so an edge is
    // simply inactive-last-cycle followed by active-this-cycle.
    assign act_now  = cond ^ polarity;
    assign act_old  = hist ^ polarity;
    assign edge_evt = act_now & ~act_old & ~mode;

    // One-hot of the current channel; avoids indexing past NUM_IRQ when
    // 2^ID_W > NUM_IRQ.
    assign id_mask  = NUM_IRQ'(1) << irqId;
    assign cur_live = |(pending & enable & id_mask);
    assign accept   = (state == S_REQ) && irqAck && cur_live;
    assign w1c      = (cfgWe && cfgAddr == 2'd3) ? cfgData : '0;
    assign ack_clr  = accept ? id_mask : '0;
    assign req_vec  = pending & enable;

    // Level channels track the active level; edge channels latch, with a new
    // edge overriding any clear in the same cycle.
    assign pending_next = (mode & act_now)
                        | (~mode & (edge_evt | (pending & ~(w1c | ack_clr))));

    always_ff @(posedge clk) begin
        if (rst) begin
            hist     <= '0;
            pending  <= '0;
            enable   <= '0;
            mode     <= '0;
            polarity <= '0;
        end else begin
            hist    <= cond;
            pending <= pending_next;
            if (cfgWe) begin
                case (cfgAddr)
                    2'd0:    enable   <= cfgData;
                    2'd1:    mode     <= cfgData;
                    2'd2:    polarity <= cfgData;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            irqReq    <= 1'b0;
            irqActive <= 1'b0;
            irqId     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_vec) begin
                        state  <= S_REQ;
                        irqReq <= 1'b1;
                        irqId  <= lowest_index(req_vec);
                    end
                end
                S_REQ: begin
                    // Withdrawal takes precedence: an ack for a request that
                    // has just vanished is not honoured.
                    if (!cur_live) begin
                        state  <= S_IDLE;
                        irqReq <= 1'b0;
                    end else if (irqAck) begin
                        state     <= S_ACTIVE;
                        irqReq    <= 1'b0;
                        irqActive <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (irqDone) begin
                        state     <= S_IDLE;
                        irqActive <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    irqReq    <= 1'b0;
                    irqActive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_irq_controller.sv
module tb_edge_irq_controller;

    localparam int N  = 8;
    localparam int IW = 3;
`ifdef IRQ_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    // Edges from the sampling edge to irqReq high, counting the sampling edge.
    localparam int LAT = DLY + 2;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_ACT  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irqIn;
    logic          cfgWe;
    logic [1:0]    cfgAddr;
    logic [N-1:0]  cfgData;
    logic          irqAck;
    logic          irqDone;
    logic          irqReq;
    logic [IW-1:0] irqId;
    logic          irqActive;
    logic [N-1:0]  pending;

    always #5 clk = ~clk;

    edge_irq_controller #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .irqIn     (irqIn),
        .cfgWe     (cfgWe),
        .cfgAddr   (cfgAddr),
        .cfgData   (cfgData),
        .irqAck    (irqAck),
        .irqDone   (irqDone),
        .irqReq    (irqReq),
        .irqId     (irqId),
        .irqActive (irqActive),
        .pending   (pending)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [N-1:0] m_pend, m_en, m_mode, m_pol;
    logic [N-1:0] h1, h2, h3;   // irqIn as sampled 1, 2, 3 edges ago
    int           m_st;
    int           m_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock: predict from the model, clock the DUT, compare.
    task automatic cycle();
        logic [N-1:0] samp [0:3];
        logic [N-1:0] cond, hist, w1c, np, ne, nm, npol;
        bit           live, accept, found, a_now, a_old;
        int           nst, nid;
        samp[0] = irqIn; samp[1] = h1; samp[2] = h2; samp[3] = h3;
        if (rst) begin
            np = '0; ne = '0; nm = '0; npol = '0; nst = M_IDLE; nid = 0;
        end else begin
            cond   = samp[DLY];
            hist   = samp[DLY + 1];
            live   = m_pend[m_id] && m_en[m_id];
            accept = (m_st == M_REQ) && irqAck && live;
            w1c    = (cfgWe && cfgAddr == 2'd3) ? cfgData : '0;
            for (int i = 0; i < N; i++) begin
                a_now = cond[i] ^ m_pol[i];
                a_old = hist[i] ^ m_pol[i];
                if (m_mode[i]) np[i] = a_now;
                else if (a_now && !a_old) np[i] = 1'b1;
                else if (w1c[i] || (accept && m_id == i)) np[i] = 1'b0;
                else np[i] = m_pend[i];
            end
            ne = m_en; nm = m_mode; npol = m_pol;
            if (cfgWe) begin
                if (cfgAddr == 2'd0) ne = cfgData;
                if (cfgAddr == 2'd1) nm = cfgData;
                if (cfgAddr == 2'd2) npol = cfgData;
            end
            nst = m_st; nid = m_id;
            if (m_st == M_IDLE) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && m_pend[i] && m_en[i]) begin
                        found = 1; nst = M_REQ; nid = i;
                    end
                end
            end else if (m_st == M_REQ) begin
                if (!live) nst = M_IDLE;
                else if (irqAck) nst = M_ACT;
            end else if (irqDone) begin
                nst = M_IDLE;
            end
        end
        @(posedge clk);
        if (rst) begin
            h3 = '0; h2 = '0; h1 = '0;
        end else begin
            h3 = h2; h2 = h1; h1 = irqIn;
        end
        m_pend = np; m_en = ne; m_mode = nm; m_pol = npol; m_st = nst; m_id = nid;
        #1;
        check("irqReq",    32'(irqReq),    32'(m_st == M_REQ));
        check("irqActive", 32'(irqActive), 32'(m_st == M_ACT));
        check("irqId",     32'(irqId),     32'(m_id));
        check("pending",   32'(pending),   32'(m_pend));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
        cfgWe = 1'b1; cfgAddr = a; cfgData = d;
        cycle();
        cfgWe = 1'b0; cfgAddr = 2'd0; cfgData = '0;
    endtask

    task automatic ack();
        irqAck = 1'b1; cycle(); irqAck = 1'b0;
    endtask

    task automatic done();
        irqDone = 1'b1; cycle(); irqDone = 1'b0;
    endtask

    task automatic do_reset();
        irqIn = '0; rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irqIn = '0; cfgWe = 1'b0; cfgAddr = 2'd0; cfgData = '0;
        irqAck = 1'b0; irqDone = 1'b0;
        m_pend = '0; m_en = '0; m_mode = '0; m_pol = '0; h1 = '0; h2 = '0; h3 = '0;
        m_st = M_IDLE; m_id = 0;
        idle(2);
        check("rst_req",  32'(irqReq), 32'd0);
        check("rst_id",   32'(irqId), 32'd0);
        check("rst_act",  32'(irqActive), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        rst = 1'b0;

        // Falling edge on channel 5 and full service cycle.
        wr(2'd2, 8'h20);
        irqIn = 8'h20;
        idle(3);
        wr(2'd3, 8'hFF);
        wr(2'd0, 8'h20);
        idle(2);
        check("fall_quiet", 32'(irqReq), 32'd0);
        irqIn = 8'h00;
        idle(LAT - 1);
        check("fall_early", 32'(irqReq), 32'd0);
        idle(1);
        check("fall_req", 32'(irqReq), 32'd1);
        check("fall_id",  32'(irqId), 32'd5);
        ack();
        check("fall_active", 32'(irqActive), 32'd1);
        check("fall_pend5",  32'(pending[5]), 32'd0);
        done();
        check("fall_done_act", 32'(irqActive), 32'd0);
        check("fall_done_req", 32'(irqReq), 32'd0);

        // Simultaneous edges on 2 and 6: priority order.
        do_reset();
        wr(2'd0, 8'h44);
        irqIn = 8'h44;
        idle(LAT);
        check("prio_first", 32'(irqId), 32'd2);
        check("prio_req",   32'(irqReq), 32'd1);
        ack();
        done();
        idle(1);
        check("prio_second_req", 32'(irqReq), 32'd1);
        check("prio_second_id",  32'(irqId), 32'd6);
        ack();
        done();

        // Disabled channel still latches; enabling it raises the request.
        do_reset();
        irqIn = 8'h08;
        idle(LAT);
        check("dis_pend", 32'(pending), 32'h08);
        check("dis_req",  32'(irqReq), 32'd0);
        wr(2'd0, 8'h08);
        check("en_req_wait", 32'(irqReq), 32'd0);
        idle(1);
        check("en_req", 32'(irqReq), 32'd1);
        check("en_id",  32'(irqId), 32'd3);

        // Request withdrawn by write-1-to-clear.
        do_reset();
        wr(2'd0, 8'h02);
        irqIn = 8'h02;
        idle(LAT);
        check("wd_req", 32'(irqReq), 32'd1);
        check("wd_id",  32'(irqId), 32'd1);
        wr(2'd3, 8'h02);
        check("wd_pend", 32'(pending), 32'd0);
        idle(1);
        check("wd_drop", 32'(irqReq), 32'd0);
        check("wd_act",  32'(irqActive), 32'd0);

        // Level mode on channel 0, then reset during service.
        do_reset();
        wr(2'd1, 8'h01);
        wr(2'd0, 8'h01);
        irqIn = 8'h01;
        idle(LAT);
        check("lvl_req", 32'(irqReq), 32'd1);
        ack();
        check("lvl_active", 32'(irqActive), 32'd1);
        check("lvl_pend",   32'(pending[0]), 32'd1);
        done();
        check("lvl_done", 32'(irqActive), 32'd0);
        idle(1);
        check("lvl_rereq", 32'(irqReq), 32'd1);
        ack();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("lvl_rst_req",  32'(irqReq), 32'd0);
        check("lvl_rst_act",  32'(irqActive), 32'd0);
        check("lvl_rst_id",   32'(irqId), 32'd0);
        check("lvl_rst_pend", 32'(pending), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) irqIn = irqIn ^ N'(1 << $urandom_range(0, N - 1));
            cfgWe   = ($urandom_range(0, 9) == 0);
            cfgAddr = 2'($urandom_range(0, 3));
            cfgData = N'($urandom);
            irqAck  = ($urandom_range(0, 2) == 0);
            irqDone = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; cfgWe = 1'b0; irqAck = 1'b0; irqDone = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
